bzmusic_play_sched: RTL

- Playback scheduler for the buzzer music path.
- Accepts user play/pause/stop/next requests and selects one of NUM_SONGS songs stored in fixed, equal-size partitions of the note ROM.
- Fetches note words in sequence, times each note and the inter-note gap against an external tick, and drives tune_code/tune_en to the tone PWM.
- Sits between the key debouncers and the note ROM plus tone PWM. It replaces hard-wired single-song sequencing.

---
 rtl/bzmusic_play_sched.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bzmusic_play_sched.sv
// Buzzer music playback scheduler: picks a song partition, fetches note
// words, times notes and gaps against tick, and drives the tone PWM.
// Ports: clk, rstn (async, active-high); play/pause/stop/next_req pulses,
// song_sel, loop_en, tick; rom_addr/rom_rd/rom_data to the note ROM;
// tune_code/tune_en to the PWM; song_idx, busy, paused, song_done status.
module bzmusic_play_sched #(
  parameter int ADDR_W    = 8,
  parameter int SONG_W    = 2,
  parameter int NOTE_W    = 5,
  parameter int DUR_W     = 4,
  parameter int GAP_TICKS = 1,
  parameter int ROM_LAT   = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    play_req,
  input  logic                    pause_req,
  input  logic                    stop_req,
  input  logic                    next_req,
  input  logic [SONG_W-1:0]       song_sel,
  input  logic                    loop_en,
  input  logic                    tick,
  output logic [ADDR_W-1:0]       rom_addr,
  output logic                    rom_rd,
  input  logic [NOTE_W+DUR_W-1:0] rom_data,
  output logic [NOTE_W-1:0]       tune_code,
  output logic                    tune_en,
  output logic [SONG_W-1:0]       song_idx,
  output logic                    busy,
  output logic                    paused,
  output logic                    song_done
);

  localparam int OFS_W = ADDR_W - SONG_W;
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int GAP_M1 = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_M1);
  localparam logic [1:0] LAT_LAST = 2'(ROM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_PLAY,
    S_GAP,
    S_ADV,
    S_PAUSE
  } state_t;

  state_t state, state_d;
  state_t ret_state, ret_d;

  logic [ADDR_W-1:0]       addr_d;
  logic [NOTE_W-1:0]       code_d;
  logic                    en_d;
  logic [SONG_W-1:0]       song_d;
  logic                    done_d;
  logic                    rd_d;
  logic                    busy_d;
  logic                    paused_d;
  logic [DUR_W-1:0]        dur_cnt, dur_d;
  logic [GAP_W-1:0]        gap_cnt, gap_d;
  logic [1:0]              lat_cnt, lat_d;
  logic [NOTE_W+DUR_W-1:0] data_q, data_d;
  logic                    pend, pend_d;
  logic                    end_hit;

  logic [NOTE_W-1:0] note_q;
  logic [DUR_W-1:0]  dur_q;
  logic [SONG_W-1:0] song_nxt;

  assign note_q   = data_q[NOTE_W+DUR_W-1:DUR_W];
  assign dur_q    = data_q[DUR_W-1:0];
  assign song_nxt = song_idx + SONG_W'(1);

  function automatic logic [ADDR_W-1:0] base_of(
    input logic [SONG_W-1:0] s
  );
    return {s, {OFS_W{1'b0}}};
  endfunction

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state     <= S_IDLE;
      ret_state <= S_IDLE;
      rom_addr  <= '0;
      rom_rd    <= 1'b0;
      tune_code <= '0;
      tune_en   <= 1'b0;
      song_idx  <= '0;
      busy      <= 1'b0;
      paused    <= 1'b0;
      song_done <= 1'b0;
      dur_cnt   <= '0;
      gap_cnt   <= '0;
      lat_cnt   <= '0;
      data_q    <= '0;
      pend      <= 1'b0;
    end else begin
      state     <= state_d;
      ret_state <= ret_d;
      rom_addr  <= addr_d;
      rom_rd    <= rd_d;
      tune_code <= code_d;
      tune_en   <= en_d;
      song_idx  <= song_d;
      busy      <= busy_d;
      paused    <= paused_d;
      song_done <= done_d;
      dur_cnt   <= dur_d;
      gap_cnt   <= gap_d;
      lat_cnt   <= lat_d;
      data_q    <= data_d;
      pend      <= pend_d;
    end
  end

  always_comb begin
    state_d = state;
    ret_d   = ret_state;
    addr_d  = rom_addr;
    code_d  = tune_code;
    en_d    = tune_en;
    song_d  = song_idx;
    done_d  = 1'b0;
    dur_d   = dur_cnt;
    gap_d   = gap_cnt;
    lat_d   = lat_cnt;
    data_d  = data_q;
    pend_d  = pend;
    end_hit = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (play_req) begin
          song_d  = song_sel;
          addr_d  = base_of(song_sel);
          pend_d  = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (pause_req) pend_d = 1'b1;
        lat_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pause_req) pend_d = 1'b1;
        // ROM word is valid ROM_LAT cycles after the read strobe
        if (lat_cnt == LAT_LAST) begin
          data_d  = rom_data;
          state_d = S_DECODE;
        end else begin
          lat_d = lat_cnt + 2'd1;
        end
      end
      S_DECODE: begin
        if (pause_req) pend_d = 1'b1;
        if (dur_q == '0) begin
          end_hit = 1'b1;
        end else begin
          code_d = note_q;
          dur_d  = dur_q;
          gap_d  = '0;
          // a deferred pause lands the moment the note would start
          if (pend || pause_req) begin
            en_d    = 1'b0;
            pend_d  = 1'b0;
            ret_d   = S_PLAY;
            state_d = S_PAUSE;
          end else begin
            en_d    = (note_q != '0);
            state_d = S_PLAY;
          end
        end
      end
      S_PLAY: begin
        if (pause_req) begin
          en_d    = 1'b0;
          ret_d   = S_PLAY;
          state_d = S_PAUSE;
        end else if (tick) begin
          dur_d = dur_cnt - DUR_W'(1);
          if (dur_cnt == DUR_W'(1)) begin
            en_d    = 1'b0;
            gap_d   = '0;
            state_d = (GAP_TICKS > 0) ? S_GAP : S_ADV;
          end
        end
      end
      S_GAP: begin
        if (pause_req) begin
          en_d    = 1'b0;
          ret_d   = S_GAP;
          state_d = S_PAUSE;
        end else if (tick) begin
          if (gap_cnt == GAP_LAST) begin
            state_d = S_ADV;
          end else begin
            gap_d = gap_cnt + GAP_W'(1);
          end
        end
      end
      S_ADV: begin
        if (pause_req) pend_d = 1'b1;
        // last word of the partition acts as an implicit end marker
        if (&rom_addr[OFS_W-1:0]) begin
          end_hit = 1'b1;
        end else begin
          addr_d  = rom_addr + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_PAUSE: begin
        if (play_req) begin
          state_d = ret_state;
          en_d    = (ret_state == S_PLAY) && (tune_code != '0);
        end
      end
    endcase

    if (end_hit) begin
      if (loop_en) begin
        addr_d  = base_of(song_idx);
        state_d = S_FETCH;
      end else begin
        done_d  = 1'b1;
        en_d    = 1'b0;
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end
    end

    // stop outranks next; both outrank whatever the state decided
    if (stop_req) begin
      song_d  = song_idx;
      addr_d  = rom_addr;
      en_d    = 1'b0;
      pend_d  = 1'b0;
      done_d  = 1'b0;
      state_d = S_IDLE;
    end else if (next_req && (state != S_IDLE)) begin
      song_d  = song_nxt;
      addr_d  = base_of(song_nxt);
      en_d    = 1'b0;
      pend_d  = 1'b0;
      done_d  = 1'b0;
      state_d = S_FETCH;
    end

    rd_d     = (state_d == S_FETCH);
    busy_d   = (state_d != S_IDLE);
    paused_d = (state_d == S_PAUSE);
  end

endmodule
